// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle arithmetic/logic ops,
// shift-add unsigned multiply and restoring unsigned divide, results held until consumed.
//
// state  | meaning
// S_IDLE | waiting for a request, o_ready high
// S_MUL  | one multiplier bit per cycle, N cycles
// S_DIV  | one quotient bit per cycle, N cycles
// S_FIN  | result/flags written into the output registers
// S_DONE | o_valid high, result held until i_ready
module alu_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         zero,
    output logic         overflow,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_SLT  = 3'd4;
    localparam logic [2:0] OP_MULU = 3'd5;
    localparam logic [2:0] OP_DIVU = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    a_r, b_r;
    logic [2:0]      op_r;
    logic [N-1:0]    hi_r, lo_r;
    logic [CW-1:0]   cnt;
    logic            cnt_tc;

    logic [N:0]      mul_sum;
    logic [N:0]      div_shift;
    logic [N-1:0]    div_diff;
    logic            div_ge;

    logic [N-1:0]    add_sum, sub_diff;
    logic [N-1:0]    fin_lo, fin_hi;
    logic            fin_ov, fin_dbz;

    assign o_ready = (state == S_IDLE);
    assign o_valid = (state == S_DONE);
    assign cnt_tc  = (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    if (op == OP_MULU)                  state_nxt = S_MUL;
                    else if (op == OP_DIVU && b != '0)  state_nxt = S_DIV;
                    else                                state_nxt = S_FIN;
                end
            end
            S_MUL, S_DIV: if (cnt_tc) state_nxt = S_FIN;
            S_FIN:        state_nxt = S_DONE;
            S_DONE:       if (i_ready) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // {hi_r, lo_r} doubles as the product register (multiplier shifts out of lo_r)
    // and as {remainder, dividend/quotient} during division.
    always_comb begin
        mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : '0);
        div_shift = {hi_r, lo_r[N-1]};
        div_ge    = (div_shift >= {1'b0, b_r});
        div_diff  = div_shift[N-1:0] - b_r;
    end

    always_comb begin
        add_sum  = a_r + b_r;
        sub_diff = a_r - b_r;
        fin_lo   = '0;
        fin_hi   = '0;
        fin_ov   = 1'b0;
        fin_dbz  = 1'b0;
        case (op_r)
            OP_ADD: begin
                fin_lo = add_sum;
                fin_ov = (a_r[N-1] == b_r[N-1]) && (add_sum[N-1] != a_r[N-1]);
            end
            OP_SUB: begin
                fin_lo = sub_diff;
                fin_ov = (a_r[N-1] != b_r[N-1]) && (sub_diff[N-1] != a_r[N-1]);
            end
            OP_AND:  fin_lo = a_r & b_r;
            OP_OR:   fin_lo = a_r | b_r;
            OP_SLT:  fin_lo = {{(N-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
            OP_MULU: begin
                fin_lo = lo_r;
                fin_hi = hi_r;
            end
            OP_DIVU: begin
                if (b_r == '0) begin
                    fin_lo  = '1;
                    fin_hi  = a_r;
                    fin_dbz = 1'b1;
                end else begin
                    fin_lo = lo_r;
                    fin_hi = hi_r;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            op_r        <= '0;
            hi_r        <= '0;
            lo_r        <= '0;
            cnt         <= '0;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        a_r  <= a;
                        b_r  <= b;
                        op_r <= op;
                        cnt  <= CW'(N);
                        hi_r <= '0;
                        lo_r <= (op == OP_MULU) ? b : a;
                    end
                end
                S_MUL: begin
                    hi_r <= mul_sum[N:1];
                    lo_r <= {mul_sum[0], lo_r[N-1:1]};
                    cnt  <= cnt - CW'(1);
                end
                S_DIV: begin
                    hi_r <= div_ge ? div_diff : div_shift[N-1:0];
                    lo_r <= {lo_r[N-2:0], div_ge};
                    cnt  <= cnt - CW'(1);
                end
                S_FIN: begin
                    result      <= fin_lo;
                    result_hi   <= fin_hi;
                    zero        <= (fin_lo == '0);
                    overflow    <= fin_ov;
                    div_by_zero <= fin_dbz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed boundary cases with literal expectations plus
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_alu_seq;

    localparam int N = 32;
    localparam longint MAXS = (longint'(1) << (N - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (N - 1));

    logic         clk, rst, i_valid, o_ready, o_valid, i_ready;
    logic [N-1:0] a, b, result, result_hi;
    logic [2:0]   op;
    logic         zero, overflow, div_by_zero;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_acc = 0, n_done = 0, n_issued = 0;

    typedef struct {
        logic [N-1:0] lo, hi;
        logic         z, ov, dbz;
        int           lat;
        int           acc;
    } exp_t;

    exp_t expq[$];
    exp_t e_mon;
    bit   seen = 0;

    alu_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .a(a), .b(b), .op(op), .o_valid(o_valid), .i_ready(i_ready),
        .result(result), .result_hi(result_hi), .zero(zero),
        .overflow(overflow), .div_by_zero(div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t           e;
        longint         sx, sy, t;
        logic [2*N-1:0] p;
        e.lo = '0; e.hi = '0; e.ov = 1'b0; e.dbz = 1'b0; e.lat = 1; e.acc = 0;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            3'd0: begin t = sx + sy; e.lo = x + y; e.ov = (t > MAXS) || (t < MINS); end
            3'd1: begin t = sx - sy; e.lo = x - y; e.ov = (t > MAXS) || (t < MINS); end
            3'd2: e.lo = x & y;
            3'd3: e.lo = x | y;
            3'd4: e.lo[0] = (sx < sy);
            3'd5: begin
                p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
                e.lo = p[N-1:0];
                e.hi = p[2*N-1:N];
                e.lat = N + 1;
            end
            3'd6: begin
                if (y == '0) begin
                    e.lo = '1; e.hi = x; e.dbz = 1'b1;
                end else begin
                    e.lo = x / y; e.hi = x % y; e.lat = N + 1;
                end
            end
            default: ;
        endcase
        e.z = (e.lo == '0);
        return e;
    endfunction

    // Handshake observer: requests enter the queue on accept, leave on handoff.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            if (i_valid && o_ready) begin
                e = model(op, a, b);
                e.acc = cyc;
                expq.push_back(e);
                n_acc++;
            end
            if (o_valid && i_ready) begin
                if (expq.size() > 0) void'(expq.pop_front());
                n_done++;
                seen = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (expq.size() == 0) begin
                chk("idle_valid", 64'(o_valid), 64'(0));
                chk("idle_ready", 64'(o_ready), 64'(1));
            end else begin
                e_mon = expq[0];
                chk("busy_ready", 64'(o_ready), 64'(0));
                if (o_valid) begin
                    if (!seen) begin
                        chk("latency", 64'(cyc - e_mon.acc), 64'(e_mon.lat));
                        seen = 1;
                    end
                    chk("result", 64'(result), 64'(e_mon.lo));
                    chk("result_hi", 64'(result_hi), 64'(e_mon.hi));
                    chk("zero", 64'(zero), 64'(e_mon.z));
                    chk("overflow", 64'(overflow), 64'(e_mon.ov));
                    chk("div_by_zero", 64'(div_by_zero), 64'(e_mon.dbz));
                end
            end
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [N-1:0] xa, input logic [N-1:0] xb,
                         input int stall, input bit hold,
                         output logic [N-1:0] r_lo, output logic [N-1:0] r_hi,
                         output logic f_z, output logic f_ov, output logic f_dbz, output int lat);
        int t;
        r_lo = '0; r_hi = '0; f_z = 1'b0; f_ov = 1'b0; f_dbz = 1'b0;
        @(negedge clk);
        t = 0;
        while (!o_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready) begin
            chk("ready_timeout", 64'(0), 64'(1));
            lat = -1;
            return;
        end
        i_valid = 1'b1; op = o; a = xa; b = xb;
        n_issued++;
        @(negedge clk);
        if (!hold) i_valid = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        lat = 0;
        while (!o_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!o_valid) begin
            chk("valid_timeout", 64'(0), 64'(1));
            i_valid = 1'b0;
            return;
        end
        r_lo = result; r_hi = result_hi; f_z = zero; f_ov = overflow; f_dbz = div_by_zero;
        repeat (stall) @(negedge clk);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        i_valid = 1'b0;
        chk("ready_after_handoff", 64'(o_ready), 64'(1));
    endtask

    logic [N-1:0] r_lo, r_hi, ra, rb;
    logic         f_z, f_ov, f_dbz;
    int           lat;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; a = '0; b = '0; op = '0;
        #1;
        chk("rst_ready", 64'(o_ready), 64'(1));
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_result_hi", 64'(result_hi), 64'(0));
        chk("rst_flags", 64'({zero, overflow, div_by_zero}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, r_lo, r_hi, f_z, f_ov, f_dbz, lat);
        chk("add_ovf_result", 64'(r_lo), 64'(32'h8000_0000));
        chk("add_ovf_flag", 64'(f_ov), 64'(1));
        chk("add_lat", 64'(lat), 64'(1));

        // Abort a multiply in flight; reset must clear outputs without a clock edge.
        @(negedge clk);
        i_valid = 1'b1; op = 3'd5; a = $urandom; b = $urandom;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", 64'(o_valid), 64'(0));
        chk("abort_ready", 64'(o_ready), 64'(1));
        chk("abort_result", 64'(result), 64'(0));
        chk("abort_result_hi", 64'(result_hi), 64'(0));
        expq.delete();
        seen = 0;
        @(negedge clk);
        n_acc = 0; n_done = 0; n_issued = 0;
        rst = 1'b0;

        do_op(3'd1, 32'd5, 32'd5, 0, 0, r_lo, r_hi, f_z, f_ov, f_dbz, lat);
        chk("sub_zero_result", 64'(r_lo), 64'(0));
        chk("sub_zero_flag", 64'(f_z), 64'(1));
        chk("sub_zero_ovf", 64'(f_ov), 64'(0));

        do_op(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, r_lo, r_hi, f_z, f_ov, f_dbz, lat);
        chk("mul_max_hi", 64'(r_hi), 64'(32'hFFFF_FFFE));
        chk("mul_max_lo", 64'(r_lo), 64'(32'h0000_0001));
        chk("mul_lat", 64'(lat), 64'(N + 1));

        do_op(3'd5, 32'd0, 32'h1234, 0, 0, r_lo, r_hi, f_z, f_ov, f_dbz, lat);
        chk("mul_zero_flag", 64'(f_z), 64'(1));

        do_op(3'd6, 32'h64, 32'h7, 0, 0, r_lo, r_hi, f_z, f_ov, f_dbz, lat);
        chk("div_quot", 64'(r_lo), 64'(32'h0000_000E));
        chk("div_rem", 64'(r_hi), 64'(32'h0000_0002));
        chk("div_lat", 64'(lat), 64'(N + 1));

        do_op(3'd6, 32'hABCD, 32'h0, 0, 0, r_lo, r_hi, f_z, f_ov, f_dbz, lat);
        chk("div0_result", 64'(r_lo), 64'(32'hFFFF_FFFF));
        chk("div0_hi", 64'(r_hi), 64'(32'h0000_ABCD));
        chk("div0_flag", 64'(f_dbz), 64'(1));
        chk("div0_lat", 64'(lat), 64'(1));

        do_op(3'd4, 32'hFFFF_FFFF, 32'h1, 0, 0, r_lo, r_hi, f_z, f_ov, f_dbz, lat);
        chk("slt_neg", 64'(r_lo), 64'(1));

        do_op(3'd7, 32'h1234_5678, 32'h9, 0, 0, r_lo, r_hi, f_z, f_ov, f_dbz, lat);
        chk("reserved_result", 64'(r_lo), 64'(0));
        chk("reserved_ovf", 64'(f_ov), 64'(0));

        // Consumer stalls for 10 cycles; the observer checks the held result each cycle.
        do_op(3'd3, 32'hF0F0_0000, 32'h0000_0F0F, 10, 1, r_lo, r_hi, f_z, f_ov, f_dbz, lat);
        chk("or_stall_result", 64'(r_lo), 64'(32'hF0F0_0F0F));

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = N'($urandom_range(0, 15));
            do_op(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  r_lo, r_hi, f_z, f_ov, f_dbz, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(expq.size()), 64'(0));
        chk("accept_count", 64'(n_acc), 64'(n_issued));
        chk("handoff_count", 64'(n_done), 64'(n_issued));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
